block_quantizer: RTL
====================

BLOCK_QUANTIZER -- requirements
Module: block_quantizer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 16: signed width of each input element.
REQ-002 SHALL have parameter IN_SIZE, default 4: elements per row (columns).
REQ-003 SHALL have parameter IN_PARALLELISM, default 1: rows per beat; N = IN_SIZE*IN_PARALLELISM elements per beat.
REQ-004 SHALL have parameter OUT_WIDTH, default 8: signed width of each quantized element, 2 <= OUT_WIDTH <= IN_WIDTH.
REQ-005 SHALL have parameter SHIFT_WIDTH, default $clog2(IN_WIDTH)+1: width of the shift exponent output.
REQ-006 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-007 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-008 SHALL have port data_in, input, array [N-1:0] of IN_WIDTH: signed block elements.
REQ-009 SHALL have port max_num, input, IN_WIDTH: unsigned block magnitude bound, qualified by data_in_valid and sampled with data_in.
REQ-010 SHALL have ports data_in_valid (input, 1) and data_in_ready (output, 1): upstream handshake.
REQ-011 SHALL have port data_out, output, array [N-1:0] of OUT_WIDTH: signed quantized elements.
REQ-012 SHALL have port shift_out, output, SHIFT_WIDTH: unsigned right-shift applied to the beat, synchronous with data_out.
REQ-013 SHALL have ports data_out_valid (output, 1) and data_out_ready (input, 1): downstream handshake.

Function
REQ-014 SHALL transfer a beat on any edge where valid and ready are both high; otherwise no transfer.
REQ-015 SHALL implement two register stages, S1 and S2, each with its own valid bit.
REQ-016 S1 SHALL capture data_in and the shift s computed from max_num on upstream transfer.
REQ-017 S2 SHALL capture the shifted, saturated elements and s from S1; S2 holds data_out, shift_out and data_out_valid.
REQ-018 shift: p = index of the most significant 1 in max_num (unsigned); s = max(0, p-(OUT_WIDTH-2)); s = 0 when max_num = 0.
REQ-019 element i SHALL be data_in[i] arithmetically right-shifted by s, floor rounding, then saturated to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-020 S2 SHALL load when S2 is empty or data_out_ready is high; S1 SHALL advance into S2 under the same condition.
REQ-021 data_in_ready SHALL equal !S1.valid || (S2 load condition), combinationally; data_in_valid SHALL NOT feed data_in_ready.
REQ-022 Latency SHALL be 2 cycles from upstream transfer to data_out_valid when there is no backpressure.
REQ-023 Throughput SHALL be 1 beat per cycle while data_out_ready is held high.
REQ-024 SHALL hold data_out and shift_out stable while data_out_valid && !data_out_ready.
REQ-025 Under sustained backpressure SHALL hold at most 2 beats, then deassert data_in_ready; SHALL NOT drop or duplicate beats.
REQ-026 Simultaneous S2 drain and S1 refill in one cycle SHALL be lossless.
REQ-027 SHALL preserve beat order; shift_out SHALL always pair with its own beat.
REQ-028 SHALL treat max_num = 2^(IN_WIDTH-1) as unsigned, giving p = IN_WIDTH-1.

Reset
REQ-029 While rst is high at an edge, SHALL clear both valid bits and set data_out to all zero and shift_out to 0.
REQ-030 data_out_valid SHALL be 0 and data_in_ready SHALL be 1 in the cycle after reset.
REQ-031 Reset mid-operation SHALL discard all in-flight beats, with no output of them after reset.

Verification (IN_WIDTH=16, OUT_WIDTH=8, N=4)
REQ-032 max_num=100, data {100,-100,3,0}, ready=1 -> 2 cycles later shift_out=0, data_out={100,-100,3,0}.
REQ-033 max_num=1000, data {1000,-1000,7,-7} -> shift_out=3, data_out={125,-125,0,-1}.
REQ-034 max_num=16'h8000, data {-32768,32767,512,-1} -> shift_out=9, data_out={-64,63,1,-1}; max_num=0, data all 0 -> shift_out=0, data_out all 0.
REQ-035 max_num=10, data {1000,-1000,5,-5} -> shift_out=0, data_out={127,-128,5,-5} (saturation).
REQ-036 data_out_ready=0, offer 4 beats back-to-back -> exactly 2 accepted, data_in_ready=0 and output held stable; release ready -> 4 beats out in order, no gaps; random ready/valid run checked against a scoreboard.
REQ-037 Assert rst with 2 beats in flight -> next cycle data_out_valid=0, data_out=0, shift_out=0, data_in_ready=1; neither beat ever emitted.

Source files
------------

// File: rtl/block_quantizer.sv
// Two-stage block quantizer: derives a common right-shift from the block magnitude bound,
// then shifts and saturates every element of the beat to OUT_WIDTH bits.
module block_quantizer #(
    parameter int IN_WIDTH       = 16,
    parameter int IN_SIZE        = 4,
    parameter int IN_PARALLELISM = 1,
    parameter int OUT_WIDTH      = 8,
    parameter int SHIFT_WIDTH    = $clog2(IN_WIDTH) + 1
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic [IN_SIZE*IN_PARALLELISM-1:0][IN_WIDTH-1:0]      data_in,
    input  logic [IN_WIDTH-1:0]                                  max_num,
    input  logic                                                 data_in_valid,
    output logic                                                 data_in_ready,
    output logic [IN_SIZE*IN_PARALLELISM-1:0][OUT_WIDTH-1:0]     data_out,
    output logic [SHIFT_WIDTH-1:0]                               shift_out,
    output logic                                                 data_out_valid,
    input  logic                                                 data_out_ready
);

    localparam int N = IN_SIZE * IN_PARALLELISM;
    localparam logic signed [IN_WIDTH-1:0] SAT_MAX = IN_WIDTH'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [IN_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    logic [N-1:0][IN_WIDTH-1:0]  s1_data_q, s1_data_d;
    logic [SHIFT_WIDTH-1:0]      s1_shift_q, s1_shift_d;
    logic                        s1_valid_q, s1_valid_d;
    logic [N-1:0][OUT_WIDTH-1:0] s2_data_q, s2_data_d;
    logic [SHIFT_WIDTH-1:0]      s2_shift_q, s2_shift_d;
    logic                        s2_valid_q, s2_valid_d;

    logic                        s2_load;
    logic                        in_fire;
    int                          msb_idx;
    logic [SHIFT_WIDTH-1:0]      shift_calc;
    logic signed [IN_WIDTH-1:0]  shifted [N];
    logic [N-1:0][OUT_WIDTH-1:0] sat_data;

    assign s2_load       = !s2_valid_q || data_out_ready;
    assign data_in_ready = !s1_valid_q || s2_load;
    assign in_fire       = data_in_valid && data_in_ready;

    // max_num is unsigned, so 2^(IN_WIDTH-1) yields the top bit position
    always_comb begin
        msb_idx    = 0;
        shift_calc = '0;
        for (int b = 0; b < IN_WIDTH; b++) begin
            if (max_num[b]) msb_idx = b;
        end
        if (max_num != '0 && msb_idx > OUT_WIDTH - 2) begin
            shift_calc = SHIFT_WIDTH'(msb_idx - (OUT_WIDTH - 2));
        end
    end

    always_comb begin
        sat_data = '0;
        for (int i = 0; i < N; i++) begin
            shifted[i] = $signed(s1_data_q[i]) >>> s1_shift_q;
            if (shifted[i] > SAT_MAX) begin
                sat_data[i] = SAT_MAX[OUT_WIDTH-1:0];
            end else if (shifted[i] < SAT_MIN) begin
                sat_data[i] = SAT_MIN[OUT_WIDTH-1:0];
            end else begin
                sat_data[i] = shifted[i][OUT_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        s1_data_d  = s1_data_q;
        s1_shift_d = s1_shift_q;
        s1_valid_d = s1_valid_q;
        s2_data_d  = s2_data_q;
        s2_shift_d = s2_shift_q;
        s2_valid_d = s2_valid_q;

        // S1 empties into S2 first; a same-cycle upstream transfer refills it
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            s1_valid_d = 1'b0;
            if (s1_valid_q) begin
                s2_data_d  = sat_data;
                s2_shift_d = s1_shift_q;
            end
        end
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_data_d  = data_in;
            s1_shift_d = shift_calc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data_q  <= '0;
            s1_shift_q <= '0;
            s1_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_shift_q <= '0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_data_q  <= s1_data_d;
            s1_shift_q <= s1_shift_d;
            s1_valid_q <= s1_valid_d;
            s2_data_q  <= s2_data_d;
            s2_shift_q <= s2_shift_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    assign data_out       = s2_data_q;
    assign shift_out      = s2_shift_q;
    assign data_out_valid = s2_valid_q;

endmodule
